// File: rtl/instr_word_assembler_if.sv
`default_nettype none
// ============================================================================
// Module   : instr_word_assembler_if
// Purpose  : Fetch-word input stream plus assembled-instruction output bundle
//            for the instruction word assembler.
// Revision : 1.0 - initial release
// ============================================================================
interface instr_word_assembler_if #(
  parameter int WORD_W  = 16,
  parameter int MAX_EXT = 2
);
  localparam int CNT_W = $clog2(MAX_EXT + 1);

  logic                        in_valid;
  logic [WORD_W-1:0]           in_word;
  logic                        in_ready;
  logic                        stall;
  logic                        flush;
  logic                        out_valid;
  logic [WORD_W-1:0]           out_instr;
  logic [MAX_EXT*WORD_W-1:0]   out_imm;
  logic [CNT_W-1:0]            out_ext_cnt;
  logic                        len_err;

  // Fetch side / decode side driver (testbench or surrounding pipeline)
  modport master (
    output in_valid, in_word, stall, flush,
    input  in_ready, out_valid, out_instr, out_imm, out_ext_cnt, len_err
  );

  // Assembler side
  modport slave (
    input  in_valid, in_word, stall, flush,
    output in_ready, out_valid, out_instr, out_imm, out_ext_cnt, len_err
  );
endinterface
`default_nettype wire

// File: rtl/instr_word_assembler.sv
`default_nettype none
// ============================================================================
// Module   : instr_word_assembler
// Purpose  : Collects a head word plus 0..MAX_EXT immediate words and emits one
//            registered, fully assembled instruction; bubbles while collecting.
//            Supports stall (hold everything) and flush (drop partial state).
// Revision : 1.0 - initial release
// ============================================================================
module instr_word_assembler #(
  parameter int WORD_W   = 16,
  parameter int MAX_EXT  = 2,
  parameter int EXT_LSB  = 2,
  parameter int EXT_BITS = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  instr_word_assembler_if.slave  bus
);
  localparam int CNT_W = $clog2(MAX_EXT + 1);
  localparam int IMM_W = MAX_EXT * WORD_W;

  typedef enum logic [0:0] {
    HEAD    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  state_t              r_state,       w_state;
  logic [CNT_W-1:0]    r_remaining,   w_remaining;
  logic [CNT_W-1:0]    r_idx,         w_idx;
  logic [WORD_W-1:0]   r_head,        w_head;
  logic [IMM_W-1:0]    r_acc,         w_acc;
  logic [CNT_W-1:0]    r_ext_cnt,     w_ext_cnt;
  logic                r_err,         w_err;
  logic                r_out_valid,   w_out_valid;
  logic [WORD_W-1:0]   r_out_instr,   w_out_instr;
  logic [IMM_W-1:0]    r_out_imm,     w_out_imm;
  logic [CNT_W-1:0]    r_out_ext_cnt, w_out_ext_cnt;
  logic                r_len_err,     w_len_err;

  logic [EXT_BITS-1:0] w_raw;
  logic                w_raw_err;
  logic [CNT_W-1:0]    w_n;
  logic [IMM_W-1:0]    w_acc_wr;

  // Decode and clamp the extension-count field of the incoming word
  always_comb begin
    w_raw     = bus.in_word[EXT_LSB +: EXT_BITS];
    w_raw_err = (32'(w_raw) > 32'(MAX_EXT));
    w_n       = w_raw_err ? CNT_W'(MAX_EXT) : CNT_W'(w_raw);
  end

  // Accumulator with the incoming word dropped into the current slot
  always_comb begin
    w_acc_wr = r_acc;
    for (int k = 0; k < MAX_EXT; k++) begin
      if (r_idx == CNT_W'(k)) begin
        w_acc_wr[k*WORD_W +: WORD_W] = bus.in_word;
      end
    end
  end

  // Next-state and next-output logic; flush beats stall, stall beats accept
  always_comb begin
    w_state       = r_state;
    w_remaining   = r_remaining;
    w_idx         = r_idx;
    w_head        = r_head;
    w_acc         = r_acc;
    w_ext_cnt     = r_ext_cnt;
    w_err         = r_err;
    w_out_valid   = r_out_valid;
    w_out_instr   = r_out_instr;
    w_out_imm     = r_out_imm;
    w_out_ext_cnt = r_out_ext_cnt;
    w_len_err     = r_len_err;

    if (bus.flush) begin
      w_state       = HEAD;
      w_remaining   = '0;
      w_idx         = '0;
      w_head        = '0;
      w_acc         = '0;
      w_ext_cnt     = '0;
      w_err         = 1'b0;
      w_out_valid   = 1'b0;
      w_out_instr   = '0;
      w_out_imm     = '0;
      w_out_ext_cnt = '0;
      w_len_err     = 1'b0;
    end else if (!bus.stall) begin
      // Any unstalled cycle without a completed instruction is a NOP bubble
      w_out_valid   = 1'b0;
      w_out_instr   = '0;
      w_out_imm     = '0;
      w_out_ext_cnt = '0;
      w_len_err     = 1'b0;
      if (bus.in_valid) begin
        case (r_state)
          HEAD: begin
            if (w_n == '0) begin
              w_out_valid = 1'b1;
              w_out_instr = bus.in_word;
            end else begin
              w_head      = bus.in_word;
              w_ext_cnt   = w_n;
              w_remaining = w_n;
              w_idx       = '0;
              w_acc       = '0;
              w_err       = w_raw_err;
              w_state     = COLLECT;
            end
          end
          COLLECT: begin
            w_acc       = w_acc_wr;
            w_idx       = r_idx + CNT_W'(1);
            w_remaining = r_remaining - CNT_W'(1);
            if (r_remaining == CNT_W'(1)) begin
              w_out_valid   = 1'b1;
              w_out_instr   = r_head;
              w_out_imm     = w_acc_wr;
              w_out_ext_cnt = r_ext_cnt;
              w_len_err     = r_err;
              w_acc         = '0;
              w_state       = HEAD;
            end
          end
          default: w_state = HEAD;
        endcase
      end
    end
  end

  // State and output registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= HEAD;
      r_remaining   <= '0;
      r_idx         <= '0;
      r_head        <= '0;
      r_acc         <= '0;
      r_ext_cnt     <= '0;
      r_err         <= 1'b0;
      r_out_valid   <= 1'b0;
      r_out_instr   <= '0;
      r_out_imm     <= '0;
      r_out_ext_cnt <= '0;
      r_len_err     <= 1'b0;
    end else begin
      r_state       <= w_state;
      r_remaining   <= w_remaining;
      r_idx         <= w_idx;
      r_head        <= w_head;
      r_acc         <= w_acc;
      r_ext_cnt     <= w_ext_cnt;
      r_err         <= w_err;
      r_out_valid   <= w_out_valid;
      r_out_instr   <= w_out_instr;
      r_out_imm     <= w_out_imm;
      r_out_ext_cnt <= w_out_ext_cnt;
      r_len_err     <= w_len_err;
    end
  end

  assign bus.in_ready    = !bus.stall;
  assign bus.out_valid   = r_out_valid;
  assign bus.out_instr   = r_out_instr;
  assign bus.out_imm     = r_out_imm;
  assign bus.out_ext_cnt = r_out_ext_cnt;
  assign bus.len_err     = r_len_err;

endmodule
`default_nettype wire
